seq_pattern_det: RTL and testbench

//  Parametrised serial pattern detector; next generation of the fixed "111" detector.
//  - Pattern and length are programmable at run time up to MAX_LEN bits.
//  - Overlapping or non-overlapping detection is selectable.
//  - Has a qualifying enable, a registered match pulse and a saturating match counter.
//  - Sits on a 1-bit serial data path; feeds the event/status logic.

---
 rtl/seq_pattern_det.sv | 123 ++++++++++++
 tb/tb_seq_pattern_det.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_det.sv
// Programmable serial pattern detector with overlap/non-overlap modes,
// a registered match pulse and a saturating match counter.
module seq_pattern_det #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(3'b111),
   parameter int                 DEFAULT_LEN = 3,
   localparam int                LEN_W       = $clog2(MAX_LEN+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in,
   input  logic             overlap,
   input  logic             cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             clr_cnt,
   output logic             match,
   output logic             armed,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] DEF_L = LEN_W'(DEFAULT_LEN);
   localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

   typedef enum logic {FILL, DETECT} state_t;

   state_t             state, state_nxt;
   logic [MAX_LEN-1:0] pat, hist, hist_shift, len_mask;
   logic [LEN_W-1:0]   len, fill, fill_inc, fill_nxt, len_clamped;
   logic               sample, hit, match_nxt, sat_nxt;
   logic [CNT_W-1:0]   cnt_nxt;

   assign sample = en & ~cfg_load;
   assign armed  = (state == DETECT);

   // Post-shift view of the history and fill; the match decision uses these.
   always_comb begin
      hist_shift = {hist[MAX_LEN-2:0], in};
      fill_inc   = (fill == MAX_L) ? MAX_L : fill + ONE_L;
      len_mask   = '0;
      for (int i = 0; i < MAX_LEN; i++)
         len_mask[i] = (i < int'(len));
      hit = (fill_inc >= len) && ((hist_shift & len_mask) == (pat & len_mask));
   end

   always_comb begin
      len_clamped = cfg_len;
      if (cfg_len == '0)
         len_clamped = ONE_L;
      else if (cfg_len > MAX_L)
         len_clamped = MAX_L;
   end

   always_comb begin
      state_nxt = state;
      fill_nxt  = fill;
      match_nxt = 1'b0;
      if (cfg_load) begin
         state_nxt = FILL;
         fill_nxt  = '0;
      end else if (en) begin
         match_nxt = hit;
         fill_nxt  = fill_inc;
         case (state)
            FILL: begin
               if (hit && !overlap) begin
                  fill_nxt = '0;
               end else if (fill_inc >= len) begin
                  state_nxt = DETECT;
               end
            end
            DETECT: begin
               // Non-overlapping mode restarts collection after each match.
               if (hit && !overlap) begin
                  fill_nxt  = '0;
                  state_nxt = FILL;
               end
            end
            default: state_nxt = FILL;
         endcase
      end
   end

   // Clear first, then count, so a clear coinciding with a match yields 1.
   always_comb begin
      cnt_nxt = match_cnt;
      if (clr_cnt)
         cnt_nxt = '0;
      if (match_nxt && (cnt_nxt != {CNT_W{1'b1}}))
         cnt_nxt = cnt_nxt + CNT_W'(1);
      sat_nxt = &cnt_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FILL;
         pat       <= DEFAULT_PAT;
         len       <= DEF_L;
         hist      <= '0;
         fill      <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else begin
         state     <= state_nxt;
         fill      <= fill_nxt;
         match     <= match_nxt;
         match_cnt <= cnt_nxt;
         cnt_sat   <= sat_nxt;
         if (sample)
            hist <= hist_shift;
         if (cfg_load) begin
            pat <= cfg_pat;
            len <= len_clamped;
         end
      end
   end

endmodule

// File: tb/tb_seq_pattern_det.sv
// Directed + random bench for seq_pattern_det; reference model keeps the bits
// received since the last restart in a queue and compares its tail to the pattern.
module tb_seq_pattern_det;

   logic       clk = 1'b0;
   logic       rst, en, in, overlap, cfg_load, clr_cnt;
   logic [7:0] cfg_pat;
   logic [3:0] cfg_len;
   logic       match, armed, cnt_sat, match2, armed2, cnt_sat2;
   logic [7:0] match_cnt;
   logic [1:0] match_cnt2;

   int checks = 0;
   int failures = 0;

   // model state
   bit         q[$];
   logic [7:0] m_pat;
   int         m_len;
   bit         m_match;
   int         m_cnt8, m_cnt2;

   always #5 clk = ~clk;

   seq_pattern_det #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .in(in), .overlap(overlap),
      .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .clr_cnt(clr_cnt),
      .match(match), .armed(armed), .match_cnt(match_cnt), .cnt_sat(cnt_sat));

   seq_pattern_det #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .in(in), .overlap(overlap),
      .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .clr_cnt(clr_cnt),
      .match(match2), .armed(armed2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pat   = 8'b0000_0111;
      m_len   = 3;
      m_match = 1'b0;
      m_cnt8  = 0;
      m_cnt2  = 0;
   endtask

   task automatic model_edge();
      bit hit;
      if (cfg_load) begin
         m_pat   = cfg_pat;
         m_len   = (cfg_len == 0) ? 1 : (cfg_len > 8) ? 8 : int'(cfg_len);
         q.delete();
         m_match = 1'b0;
      end else if (en) begin
         q.push_back(in);
         if (q.size() > 8) void'(q.pop_front());
         hit = (q.size() >= m_len);
         for (int k = 0; k < m_len && hit; k++)
            if (q[q.size()-1-k] != m_pat[k]) hit = 1'b0;
         m_match = hit;
         if (hit && !overlap) q.delete();
      end else begin
         m_match = 1'b0;
      end
      if (clr_cnt) begin
         m_cnt8 = 0;
         m_cnt2 = 0;
      end
      if (m_match) begin
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt2 < 3)   m_cnt2++;
      end
   endtask

   task automatic check_all();
      chk("match",     match,      m_match);
      chk("armed",     armed,      q.size() >= m_len);
      chk("match_cnt", match_cnt,  m_cnt8);
      chk("cnt_sat",   cnt_sat,    m_cnt8 == 255);
      chk("cnt2",      match_cnt2, m_cnt2);
      chk("cnt_sat2",  cnt_sat2,   m_cnt2 == 3);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic bit_in(input logic b);
      en = 1'b1; in = b;
      tick();
   endtask

   task automatic idle(input logic b);
      en = 1'b0; in = b;
      tick();
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l);
      cfg_load = 1'b1; cfg_pat = p; cfg_len = l; en = 1'b1; in = 1'b1;
      tick();
      cfg_load = 1'b0;
   endtask

   // Async reset mid-cycle: outputs must drop immediately, before any edge.
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("rst_match", match, 1'b0);
      chk("rst_armed", armed, 1'b0);
      chk("rst_cnt",   match_cnt, 8'd0);
      chk("rst_sat",   cnt_sat, 1'b0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; in = 1'b0; overlap = 1'b1;
      cfg_load = 1'b0; cfg_pat = '0; cfg_len = '0; clr_cnt = 1'b0;
      model_reset();
      #12;
      check_all();
      @(negedge clk) rst = 1'b1;

      // defaults, overlapping: 5 ones -> matches after edges 3,4,5
      overlap = 1'b1;
      bit_in(1); bit_in(1);
      chk("t1_armed_pre", armed, 1'b0);
      bit_in(1);
      chk("t1_match3", match, 1'b1);
      bit_in(1); bit_in(1);
      chk("t1_cnt", match_cnt, 8'd3);

      // defaults, non-overlapping: 6 ones -> matches after 3 and 6
      do_reset();
      overlap = 1'b0;
      repeat (5) bit_in(1);
      chk("t2_match5", match, 1'b0);
      bit_in(1);
      chk("t2_match6", match, 1'b1);
      chk("t2_cnt", match_cnt, 8'd2);

      // pattern 1011, both modes
      foreach (q[i]) ;
      for (int ov = 1; ov >= 0; ov--) begin
         logic [6:0] s;
         do_reset();
         overlap = ov[0];
         load(8'b1011, 4'd4);
         s = 7'b1011011;
         for (int i = 6; i >= 0; i--) bit_in(s[i]);
         chk("t3_cnt", match_cnt, ov ? 8'd2 : 8'd1);
      end

      // en gaps hold progress; mid-sequence reset discards it
      do_reset();
      overlap = 1'b1;
      bit_in(1); bit_in(1);
      idle(0); idle(0); idle(0);
      bit_in(1);
      chk("t4_match_gap", match, 1'b1);
      do_reset();
      bit_in(1); bit_in(1);
      do_reset();
      bit_in(1); bit_in(1);
      chk("t4_no_match", match, 1'b0);
      bit_in(1);
      chk("t4_match_new", match, 1'b1);

      // narrow counter saturates; clear with a match gives 1
      do_reset();
      repeat (7) bit_in(1);
      chk("t5_cnt2", match_cnt2, 2'd3);
      chk("t5_sat2", cnt_sat2, 1'b1);
      clr_cnt = 1'b1;
      bit_in(1);
      clr_cnt = 1'b0;
      chk("t5_clr_cnt2", match_cnt2, 2'd1);
      chk("t5_clr_cnt", match_cnt, 8'd1);

      // length clamping and load mid-pattern
      do_reset();
      load(8'b0000_0001, 4'd0);
      bit_in(1);
      chk("t6_len1", match, 1'b1);
      bit_in(0); bit_in(1);
      load(8'b1010_0101, 4'd11);
      for (int i = 7; i >= 0; i--) bit_in(i[0] ? (i == 7 || i == 5) : (i == 2 || i == 0));
      chk("t6_len8", match, 1'b1);
      load(8'b0000_0111, 4'd3);
      bit_in(1); bit_in(1);
      load(8'b0000_0111, 4'd3);
      bit_in(1);
      chk("t6_load_mid", match, 1'b0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         overlap = $urandom_range(1, 0);
         clr_cnt = ($urandom_range(99, 0) < 3);
         if ($urandom_range(99, 0) < 3) begin
            cfg_load = 1'b1;
            cfg_pat  = 8'($urandom);
            cfg_len  = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0))
                                                   : 4'($urandom_range(4, 1));
         end
         en = ($urandom_range(9, 0) < 8);
         in = ($urandom_range(9, 0) < 7);
         tick();
         cfg_load = 1'b0;
         clr_cnt  = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
